health_manager: RTL and testbench

//  Game-logic owner of both fighters' health values. Drives the RyuHealth/AkumaHealth

---
 rtl/health_manager.sv | 161 ++++++++++++++++
 tb/tb_health_manager.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/health_manager.sv
// Health bookkeeping for both fighters: saturating damage with per-player invulnerability,
// a frame-paced drain of the displayed bars, and round/KO sequencing.
module health_manager #(
   parameter int MAX_HEALTH    = 246,
   parameter int DRAIN_STEP    = 2,
   parameter int INVULN_FRAMES = 30
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       round_start,
   input  logic       ryu_hit,
   input  logic [7:0] ryu_dmg,
   input  logic       akuma_hit,
   input  logic [7:0] akuma_dmg,
   output logic [7:0] RyuHealth,
   output logic [7:0] AkumaHealth,
   output logic       fight_active,
   output logic       ko,
   output logic [1:0] winner
);

   localparam logic [7:0] MAX_H  = 8'(MAX_HEALTH);
   localparam logic [7:0] STEP_H = 8'(DRAIN_STEP);
   localparam int         INV_W  = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
   localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIGHT = 2'd1,
      S_DRAIN = 2'd2,
      S_KO    = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       fight_active_q, fight_active_d;
   logic       ko_q, ko_d;
   logic [1:0] winner_q, winner_d;

   logic       reload;
   logic       in_fight;
   logic       in_play;
   logic [1:0] hit_in;
   logic [7:0] dmg_in    [2];
   logic [7:0] tgt_next  [2];
   logic [7:0] tgt_cur   [2];
   logic [7:0] disp_cur  [2];

   // Player index 0 is Ryu, 1 is Akuma throughout.
   assign hit_in    = {akuma_hit, ryu_hit};
   assign dmg_in[0] = ryu_dmg;
   assign dmg_in[1] = akuma_dmg;

   assign reload   = round_start && ((state_q == S_IDLE) || (state_q == S_KO));
   assign in_fight = (state_q == S_FIGHT);
   assign in_play  = (state_q == S_FIGHT) || (state_q == S_DRAIN);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         logic [7:0]       t_q, t_d;
         logic [7:0]       d_q, d_d;
         logic [INV_W-1:0] inv_q, inv_d;

         always_comb begin
            t_d   = t_q;
            d_d   = d_q;
            inv_d = inv_q;
            if (reload) begin
               t_d   = MAX_H;
               d_d   = MAX_H;
               inv_d = '0;
            end else if (in_play) begin
               if (frame_tick && (inv_q != '0)) begin
                  inv_d = inv_q - INV_W'(1);
               end
               // A hit on a tick cycle overrides the decrement above.
               if (in_fight && hit_in[gi] && (inv_q == '0)) begin
                  t_d   = (dmg_in[gi] >= t_q) ? 8'd0 : (t_q - dmg_in[gi]);
                  inv_d = INV_LOAD;
               end
               // Drain toward the pre-hit target so the bar lags by one tick.
               if (frame_tick && (d_q > t_q)) begin
                  d_d = ((d_q - t_q) > STEP_H) ? (d_q - STEP_H) : t_q;
               end
            end
         end

         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               t_q   <= MAX_H;
               d_q   <= MAX_H;
               inv_q <= '0;
            end else begin
               t_q   <= t_d;
               d_q   <= d_d;
               inv_q <= inv_d;
            end
         end

         assign tgt_next[gi] = t_d;
         assign tgt_cur[gi]  = t_q;
         assign disp_cur[gi] = d_q;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      case (state_q)
         S_IDLE: begin
            if (round_start) begin
               state_d  = S_FIGHT;
               winner_d = 2'b00;
            end
         end
         S_FIGHT: begin
            // winner bit1 = Ryu down, bit0 = Akuma down.
            if ((tgt_next[0] == 8'd0) || (tgt_next[1] == 8'd0)) begin
               state_d  = S_DRAIN;
               winner_d = {tgt_next[0] == 8'd0, tgt_next[1] == 8'd0};
            end
         end
         S_DRAIN: begin
            if ((disp_cur[0] == tgt_cur[0]) && (disp_cur[1] == tgt_cur[1])) begin
               state_d = S_KO;
            end
         end
         S_KO: begin
            if (round_start) begin
               state_d  = S_FIGHT;
               winner_d = 2'b00;
            end
         end
         default: state_d = S_IDLE;
      endcase
      fight_active_d = (state_d == S_FIGHT);
      ko_d           = (state_d == S_KO);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         fight_active_q <= 1'b0;
         ko_q           <= 1'b0;
         winner_q       <= 2'b00;
      end else begin
         state_q        <= state_d;
         fight_active_q <= fight_active_d;
         ko_q           <= ko_d;
         winner_q       <= winner_d;
      end
   end

   assign RyuHealth    = disp_cur[0];
   assign AkumaHealth  = disp_cur[1];
   assign fight_active = fight_active_q;
   assign ko           = ko_q;
   assign winner       = winner_q;

endmodule

// File: tb/tb_health_manager.sv
// Directed bench for health_manager: hand-computed expectations checked with immediate assertions.
module tb_health_manager;

   logic       vga_clk = 1'b0;
   logic       reset_n;
   logic       frame_tick, round_start;
   logic       ryu_hit, akuma_hit;
   logic [7:0] ryu_dmg, akuma_dmg;
   logic [7:0] RyuHealth, AkumaHealth;
   logic       fight_active, ko;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

   health_manager #(.MAX_HEALTH(246), .DRAIN_STEP(2), .INVULN_FRAMES(30)) dut (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .frame_tick   (frame_tick),
      .round_start  (round_start),
      .ryu_hit      (ryu_hit),
      .ryu_dmg      (ryu_dmg),
      .akuma_hit    (akuma_hit),
      .akuma_dmg    (akuma_dmg),
      .RyuHealth    (RyuHealth),
      .AkumaHealth  (AkumaHealth),
      .fight_active (fight_active),
      .ko           (ko),
      .winner       (winner)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge vga_clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0;
      end
   endtask

   task automatic hit(input logic r, input logic [7:0] rd, input logic a, input logic [7:0] ad,
                      input logic ft);
      ryu_hit = r; ryu_dmg = rd; akuma_hit = a; akuma_dmg = ad; frame_tick = ft;
      cyc(1);
      ryu_hit = 1'b0; akuma_hit = 1'b0; frame_tick = 1'b0; ryu_dmg = 8'd0; akuma_dmg = 8'd0;
   endtask

   task automatic start_round();
      round_start = 1'b1;
      cyc(1);
      round_start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; frame_tick = 1'b0; round_start = 1'b0;
      ryu_hit = 1'b0; akuma_hit = 1'b0; ryu_dmg = 8'd0; akuma_dmg = 8'd0;

      // Reset state
      repeat (3) @(posedge vga_clk);
      #1;
      check("rst_ryu", RyuHealth, 8'd246);
      check("rst_akuma", AkumaHealth, 8'd246);
      check("rst_fight", {7'd0, fight_active}, 8'd0);
      check("rst_ko", {7'd0, ko}, 8'd0);
      check("rst_winner", {6'd0, winner}, 8'd0);
      reset_n = 1'b1;
      cyc(1);

      // Round start
      start_round();
      check("start_fight", {7'd0, fight_active}, 8'd1);
      check("start_ryu", RyuHealth, 8'd246);
      check("start_akuma", AkumaHealth, 8'd246);
      check("start_winner", {6'd0, winner}, 8'd0);

      // Ryu hit 20, drain 2 per frame down to 226
      hit(1'b1, 8'd20, 1'b0, 8'd0, 1'b0);
      check("hit_no_tick_ryu", RyuHealth, 8'd246);
      for (int k = 1; k <= 10; k++) begin
         frames(1);
         check($sformatf("drain_ryu_%0d", k), RyuHealth, 8'(246 - 2 * k));
      end
      frames(1);
      check("drain_hold_ryu", RyuHealth, 8'd226);
      check("drain_akuma", AkumaHealth, 8'd246);

      // Invulnerability: 11 frames in, hit ignored
      hit(1'b1, 8'd50, 1'b0, 8'd0, 1'b0);
      frames(1);
      check("invuln_ignored", RyuHealth, 8'd226);
      frames(17);
      hit(1'b1, 8'd50, 1'b0, 8'd0, 1'b0);   // counter at 1: still ignored
      frames(1);
      check("invuln_last_frame", RyuHealth, 8'd226);
      hit(1'b1, 8'd50, 1'b0, 8'd0, 1'b0);   // counter expired: honoured, target 176
      frames(1);
      check("invuln_expired", RyuHealth, 8'd224);
      frames(24);
      check("ryu_at_176", RyuHealth, 8'd176);
      check("akuma_untouched", AkumaHealth, 8'd246);

      // Akuma down to target 10, then saturating hit of 200
      hit(1'b0, 8'd0, 1'b1, 8'd236, 1'b0);
      frames(118);
      check("akuma_at_10", AkumaHealth, 8'd10);
      check("still_fight", {7'd0, fight_active}, 8'd1);
      hit(1'b0, 8'd0, 1'b1, 8'd200, 1'b0);
      check("drain_fight", {7'd0, fight_active}, 8'd0);
      check("drain_winner", {6'd0, winner}, 8'd1);
      check("drain_ko", {7'd0, ko}, 8'd0);
      check("drain_akuma_held", AkumaHealth, 8'd10);
      hit(1'b1, 8'd100, 1'b0, 8'd0, 1'b0);  // ignored outside FIGHT
      frames(5);
      check("akuma_zero", AkumaHealth, 8'd0);
      check("ko_not_yet", {7'd0, ko}, 8'd0);
      cyc(1);
      check("ko_one_later", {7'd0, ko}, 8'd1);
      check("ko_ryu_kept", RyuHealth, 8'd176);

      // KO: frozen
      hit(1'b1, 8'd30, 1'b0, 8'd0, 1'b1);
      check("ko_frozen_ryu", RyuHealth, 8'd176);
      check("ko_frozen_ko", {7'd0, ko}, 8'd1);
      check("ko_frozen_winner", {6'd0, winner}, 8'd1);

      // New round, double KO
      start_round();
      check("r2_ryu", RyuHealth, 8'd246);
      check("r2_akuma", AkumaHealth, 8'd246);
      check("r2_winner", {6'd0, winner}, 8'd0);
      check("r2_fight", {7'd0, fight_active}, 8'd1);
      check("r2_ko", {7'd0, ko}, 8'd0);
      hit(1'b1, 8'd241, 1'b1, 8'd241, 1'b0);
      frames(121);
      check("both5_ryu", RyuHealth, 8'd5);
      check("both5_akuma", AkumaHealth, 8'd5);
      hit(1'b1, 8'd9, 1'b1, 8'd9, 1'b0);
      check("dko_winner", {6'd0, winner}, 8'd3);
      check("dko_fight", {7'd0, fight_active}, 8'd0);
      frames(3);
      check("dko_ryu0", RyuHealth, 8'd0);
      check("dko_akuma0", AkumaHealth, 8'd0);
      check("dko_ko_pre", {7'd0, ko}, 8'd0);
      cyc(1);
      check("dko_ko", {7'd0, ko}, 8'd1);
      check("dko_winner_ko", {6'd0, winner}, 8'd3);
      start_round();
      check("r3_ryu", RyuHealth, 8'd246);
      check("r3_akuma", AkumaHealth, 8'd246);
      check("r3_winner", {6'd0, winner}, 8'd0);

      // Hit with dmg 0 on a tick cycle: load beats decrement
      hit(1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
      hit(1'b0, 8'd0, 1'b1, 8'd6, 1'b0);
      frames(29);
      check("dmg0_invuln", AkumaHealth, 8'd246);
      hit(1'b0, 8'd0, 1'b1, 8'd6, 1'b0);
      frames(1);
      check("dmg0_last", AkumaHealth, 8'd246);
      hit(1'b0, 8'd0, 1'b1, 8'd6, 1'b0);
      frames(1);
      check("dmg0_after", AkumaHealth, 8'd244);
      start_round();                          // ignored in FIGHT
      check("rs_in_fight", AkumaHealth, 8'd244);
      check("rs_fight", {7'd0, fight_active}, 8'd1);

      // Reset mid-DRAIN
      hit(1'b1, 8'd255, 1'b0, 8'd0, 1'b0);
      check("r3_winner_akuma", {6'd0, winner}, 8'd2);
      frames(1);
      check("r3_drain_ryu", RyuHealth, 8'd244);
      reset_n = 1'b0;
      #1;
      check("async_rst_ryu", RyuHealth, 8'd246);
      check("async_rst_akuma", AkumaHealth, 8'd246);
      check("async_rst_winner", {6'd0, winner}, 8'd0);
      check("async_rst_fight", {7'd0, fight_active}, 8'd0);
      cyc(1);
      reset_n = 1'b1;
      hit(1'b1, 8'd50, 1'b1, 8'd50, 1'b1);
      cyc(2);
      check("idle_ignore_ryu", RyuHealth, 8'd246);
      check("idle_ignore_akuma", AkumaHealth, 8'd246);
      check("idle_fight", {7'd0, fight_active}, 8'd0);
      start_round();
      check("idle_start", {7'd0, fight_active}, 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
